// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with start/done handshake.
// Optional build macro BCD_SATURATE_EN: out-of-range inputs load all-9 digits instead of the mod-10^DIGITS result.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

  localparam logic [31:0]   MAX_VAL   = pow10(DIGITS) - 32'd1;
  localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

  // Every digit that is 5 or more gets +3 so the following left shift carries into the next decade.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      else                     r[4*i +: 4] = s[4*i +: 4];
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t                state_r;
  logic [BIN_WIDTH-1:0]  shift_r;
  logic [BW-1:0]         scratch_r;
  logic [CW-1:0]         cnt_r;
  logic                  ovf_pend_r;
  logic [BW-1:0]         adjusted_s;

  // Digit correction applied to the scratch before each shift.
  always_comb begin
    adjusted_s = add3(scratch_r);
  end

  // Conversion state machine with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      scratch_r  <= '0;
      cnt_r      <= '0;
      ovf_pend_r <= 1'b0;
      bcd_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            shift_r    <= bin_in;
            scratch_r  <= '0;
            cnt_r      <= CW'(BIN_WIDTH);
            ovf_pend_r <= (32'(bin_in) > MAX_VAL);
            busy       <= 1'b1;
            state_r    <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          // The scratch MSB falls off here, which is what makes the default result mod 10^DIGITS.
          scratch_r <= {adjusted_s[BW-2:0], shift_r[BIN_WIDTH-1]};
          shift_r   <= {shift_r[BIN_WIDTH-2:0], 1'b0};
          cnt_r     <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) state_r <= LOAD;
          else                 state_r <= SHIFT;
        end
        LOAD: begin
`ifdef BCD_SATURATE_EN
          bcd_out <= ovf_pend_r ? ALL_NINES : scratch_r;
`else
          bcd_out <= scratch_r;
`endif
          overflow <= ovf_pend_r;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
